// File: rtl/fifo_access_arbiter.sv
// ---------------------------------------------------------------------------
// fifo_access_arbiter
// Sequences a single-port FIFO shared by two writers and one reader. One FIFO
// operation per cycle, granted round-robin (WR0 -> WR1 -> RD). An exact
// occupancy count is kept locally so inserts are never issued when full and
// deletes never when empty; the FIFO's own Full/Empty flags are not trusted
// for control. Also generates the FIFO's sync reset (init and flush).
//
// Ports
//   clk                  system clock, rising edge
//   rst                  asynchronous active-low reset
//   flush                sync active-high: empty the FIFO
//   wr0_req/wr1_req      write requests, held until granted
//   wr0_data/wr1_data    write data, stable while request is high
//   wr0_gnt/wr1_gnt      combinational write grants
//   rd_req / rd_gnt      read request / combinational read grant
//   rd_valid / rd_data   registered read result, 2 clocks after the grant edge
//   level                committed words in the FIFO (0..2**ADDR_W-1)
//   err                  sticky: FIFO reported Full while out of reset
//   fifo_rst             FIFO sync reset, active-low
//   fifo_cs              FIFO chip select
//   fifo_insert_delete   1 = insert, 0 = delete
//   fifo_data_in         FIFO write data
//   fifo_data_out        FIFO read data
//   fifo_full            FIFO Full flag (monitored only)
//   fifo_empty           FIFO Empty flag (not used)
// ---------------------------------------------------------------------------
module fifo_access_arbiter #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              wr0_req,
    input  logic [DATA_W-1:0] wr0_data,
    output logic              wr0_gnt,
    input  logic              wr1_req,
    input  logic [DATA_W-1:0] wr1_data,
    output logic              wr1_gnt,
    input  logic              rd_req,
    output logic              rd_gnt,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic [ADDR_W-1:0] level,
    output logic              err,
    output logic              fifo_rst,
    output logic              fifo_cs,
    output logic              fifo_insert_delete,
    output logic [DATA_W-1:0] fifo_data_in,
    input  logic [DATA_W-1:0] fifo_data_out,
    input  logic              fifo_full,
    input  logic              fifo_empty
);

    // One slot of the 2**ADDR_W array is never usable, so capacity is all-ones.
    localparam logic [ADDR_W-1:0] CAP = '1;

    typedef enum logic [1:0] {
        RR_WR0 = 2'd0,
        RR_WR1 = 2'd1,
        RR_RD  = 2'd2
    } rr_t;

    rr_t               r_rr;
    rr_t               w_rr_next;
    logic [1:0]        r_init_cnt;
    logic [ADDR_W-1:0] r_count;
    logic [1:0]        r_rd_pipe;
    logic              r_rd_valid;
    logic [DATA_W-1:0] r_rd_data;
    logic              r_err;
    logic              r_fifo_rst;
    logic              r_fifo_cs;
    logic              r_fifo_id;
    logic [DATA_W-1:0] r_fifo_din;

    logic w_allow;
    logic w_el_wr0;
    logic w_el_wr1;
    logic w_el_rd;
    logic w_gnt_wr0;
    logic w_gnt_wr1;
    logic w_gnt_rd;
    logic w_unused;

    // Empty flag lags the real occupancy; control runs from r_count instead.
    assign w_unused = fifo_empty;

    assign w_allow  = (r_init_cnt == 2'd0) && !flush;
    assign w_el_wr0 = wr0_req && (r_count != CAP);
    assign w_el_wr1 = wr1_req && (r_count != CAP);
    assign w_el_rd  = rd_req  && (r_count != '0);

    // Round-robin pick starting at r_rr; pointer moves past the winner only.
    always_comb begin
        w_gnt_wr0 = 1'b0;
        w_gnt_wr1 = 1'b0;
        w_gnt_rd  = 1'b0;
        w_rr_next = r_rr;
        if (w_allow) begin
            case (r_rr)
                RR_WR0: begin
                    if (w_el_wr0)      w_gnt_wr0 = 1'b1;
                    else if (w_el_wr1) w_gnt_wr1 = 1'b1;
                    else if (w_el_rd)  w_gnt_rd  = 1'b1;
                end
                RR_WR1: begin
                    if (w_el_wr1)      w_gnt_wr1 = 1'b1;
                    else if (w_el_rd)  w_gnt_rd  = 1'b1;
                    else if (w_el_wr0) w_gnt_wr0 = 1'b1;
                end
                default: begin
                    if (w_el_rd)       w_gnt_rd  = 1'b1;
                    else if (w_el_wr0) w_gnt_wr0 = 1'b1;
                    else if (w_el_wr1) w_gnt_wr1 = 1'b1;
                end
            endcase
        end
        if (w_gnt_wr0)      w_rr_next = RR_WR1;
        else if (w_gnt_wr1) w_rr_next = RR_RD;
        else if (w_gnt_rd)  w_rr_next = RR_WR0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rr <= RR_WR0;
        end else begin
            r_rr <= w_rr_next;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_init_cnt <= 2'd2;
            r_count    <= '0;
            r_rd_pipe  <= 2'b00;
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
            r_err      <= 1'b0;
            r_fifo_rst <= 1'b0;
            r_fifo_cs  <= 1'b0;
            r_fifo_id  <= 1'b0;
            r_fifo_din <= '0;
        end else begin
            if (r_init_cnt != 2'd0) r_init_cnt <= r_init_cnt - 2'd1;
            // Held low through the last init cycle so the FIFO sees two reset edges.
            r_fifo_rst <= (r_init_cnt <= 2'd1) && !flush;
            if (fifo_full && r_fifo_rst) r_err <= 1'b1;

            // FIFO deletes at k+1; its output is captured at k+2.
            r_rd_valid <= r_rd_pipe[1] && !flush;
            if (r_rd_pipe[1] && !flush) r_rd_data <= fifo_data_out;
            r_rd_pipe <= flush ? 2'b00 : {r_rd_pipe[0], w_gnt_rd};

            if (flush) begin
                r_count   <= '0;
                r_fifo_cs <= 1'b0;
            end else begin
                r_fifo_cs <= w_gnt_wr0 || w_gnt_wr1 || w_gnt_rd;
                if (w_gnt_wr0) begin
                    r_fifo_id  <= 1'b1;
                    r_fifo_din <= wr0_data;
                    r_count    <= r_count + 1'b1;
                end else if (w_gnt_wr1) begin
                    r_fifo_id  <= 1'b1;
                    r_fifo_din <= wr1_data;
                    r_count    <= r_count + 1'b1;
                end else if (w_gnt_rd) begin
                    r_fifo_id  <= 1'b0;
                    r_count    <= r_count - 1'b1;
                end
            end
        end
    end

    assign wr0_gnt            = w_gnt_wr0;
    assign wr1_gnt            = w_gnt_wr1;
    assign rd_gnt             = w_gnt_rd;
    assign rd_valid           = r_rd_valid;
    assign rd_data            = r_rd_data;
    assign level              = r_count;
    assign err                = r_err;
    assign fifo_rst           = r_fifo_rst;
    assign fifo_cs            = r_fifo_cs;
    assign fifo_insert_delete = r_fifo_id;
    assign fifo_data_in       = r_fifo_din;

endmodule
